// File: rtl/prewish_mentor.sv
// Wishbone-style mentor that walks a table of blink masks and writes each one
// to the STUDENT's mask port. Each mask is held for a programmable dwell time, with skip and pause.
module prewish_mentor #(
  parameter int                          NUM_PATTERNS = 4,
  parameter logic [8*NUM_PATTERNS-1:0]   PATTERNS     = 32'hFF_F0_A0_80,
  parameter int                          DWELL_CYCLES = 50_000_000,
  parameter int                          ACK_TIMEOUT  = 4
) (
  input  logic       CLK_I,
  input  logic       RST_I,
  input  logic       ACK_I,
  input  logic       i_next,
  input  logic       i_pause,
  output logic       CYC_O,
  output logic       STB_O,
  output logic [7:0] DAT_O,
  output logic [3:0] o_index,
  output logic       o_err
);

  localparam int DW = $clog2(DWELL_CYCLES);
  localparam int WW = $clog2(ACK_TIMEOUT + 1);

  localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_CYCLES - 1);
  localparam logic [WW-1:0] WAIT_LAST  = WW'(ACK_TIMEOUT - 1);
  localparam logic [3:0]    IDX_LAST   = 4'(NUM_PATTERNS - 1);
  // The table is padded to the full 16 entries so any 4-bit index selects in range.
  localparam logic [127:0]  TABLE      = 128'(PATTERNS);

  typedef enum logic [1:0] {IDLE, WRITE, DWELL} state_t;

  state_t        state;
  logic [DW-1:0] dwell_cnt;
  logic [WW-1:0] wait_cnt;
  logic          pending;
  logic [3:0]    next_idx;
  logic          dwell_end;

  function automatic logic [7:0] entry(input logic [3:0] idx);
    return TABLE[{idx, 3'b000} +: 8];
  endfunction

  assign next_idx  = (o_index == IDX_LAST) ? 4'd0 : o_index + 4'd1;
  // A skip request overrides a pause, so it is checked first.
  assign dwell_end = pending || i_next || (!i_pause && dwell_cnt == DWELL_LAST);

  // The STUDENT sees a single-cycle bus, so CYC_O is just the registered strobe.
  assign CYC_O = STB_O;

  // NOTE: state is written with non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      state     <= IDLE;
      STB_O     <= 1'b0;
      DAT_O     <= 8'h00;
      o_index   <= 4'd0;
      o_err     <= 1'b0;
      dwell_cnt <= '0;
      wait_cnt  <= '0;
      pending   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          state    <= WRITE;
          STB_O    <= 1'b1;
          DAT_O    <= entry(o_index);
          wait_cnt <= '0;
        end
        WRITE: begin
          if (i_next) pending <= 1'b1;
          if (ACK_I) begin
            STB_O     <= 1'b0;
            state     <= DWELL;
            dwell_cnt <= '0;
          end else if (wait_cnt == WAIT_LAST) begin
            // An unacknowledged write still counts as done; only the error flag records it.
            STB_O     <= 1'b0;
            o_err     <= 1'b1;
            state     <= DWELL;
            dwell_cnt <= '0;
          end else begin
            wait_cnt <= wait_cnt + WW'(1);
          end
        end
        DWELL: begin
          if (dwell_end) begin
            o_index  <= next_idx;
            DAT_O    <= entry(next_idx);
            STB_O    <= 1'b1;
            pending  <= 1'b0;
            wait_cnt <= '0;
            state    <= WRITE;
          end else if (!i_pause) begin
            dwell_cnt <= dwell_cnt + DW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_prewish_mentor.sv
// Self-checking bench for prewish_mentor: a cycle-level countdown model checked
// every cycle, plus directed scenarios with hand-computed timing and data.
module tb_prewish_mentor;

  localparam int N = 3;
  localparam int D = 8;
  localparam int T = 4;

  logic       clk       = 1'b0;
  logic       rst_n     = 1'b0;
  logic       ack_force = 1'b0;
  logic       echo      = 1'b0;
  logic       next_r    = 1'b0;
  logic       pause_r   = 1'b0;
  logic       ack;
  logic       cyc_o, stb_o, err_o;
  logic [7:0] dat_o;
  logic [3:0] idx_o;

  assign ack = echo ? stb_o : ack_force;

  always #5 clk = ~clk;

  prewish_mentor #(
    .NUM_PATTERNS(N),
    .PATTERNS    (24'hFF_F0_A0),
    .DWELL_CYCLES(D),
    .ACK_TIMEOUT (T)
  ) dut (
    .CLK_I  (clk),
    .RST_I  (rst_n),
    .ACK_I  (ack),
    .i_next (next_r),
    .i_pause(pause_r),
    .CYC_O  (cyc_o),
    .STB_O  (stb_o),
    .DAT_O  (dat_o),
    .o_index(idx_o),
    .o_err  (err_o)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: a strobe lasts until ACK or until T cycles run out; a dwell is a countdown
  // of D unpaused cycles, cut short by any skip request.
  logic [7:0] pat [N] = '{8'hA0, 8'hF0, 8'hFF};
  logic       m_stb = 1'b0, m_err = 1'b0, m_skip = 1'b0, m_started = 1'b0;
  logic [7:0] m_dat = 8'h00;
  int         m_idx = 0, m_left = 0, m_rem = 0;

  task automatic launch(input int i);
    m_idx  = i;
    m_dat  = pat[i];
    m_stb  = 1'b1;
    m_left = T;
    m_skip = 1'b0;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_stb = 1'b0; m_err = 1'b0; m_skip = 1'b0; m_started = 1'b0;
      m_dat = 8'h00; m_idx = 0; m_left = 0; m_rem = 0;
    end else if (!m_started) begin
      m_started = 1'b1;
      launch(0);
    end else if (m_stb) begin
      if (next_r) m_skip = 1'b1;
      if (echo || ack_force) begin
        m_stb = 1'b0;
        m_rem = D;
      end else begin
        m_left--;
        if (m_left == 0) begin
          m_stb = 1'b0;
          m_err = 1'b1;
          m_rem = D;
        end
      end
    end else begin
      if (m_skip || next_r) launch((m_idx + 1) % N);
      else if (!pause_r) begin
        m_rem--;
        if (m_rem == 0) launch((m_idx + 1) % N);
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(posedge clk) begin
    #2;
    check("stb", 32'(stb_o), 32'(m_stb));
    check("cyc", 32'(cyc_o), 32'(m_stb));
    check("dat", 32'(dat_o), 32'(m_dat));
    check("idx", 32'(idx_o), 32'(m_idx));
    check("err", 32'(err_o), 32'(m_err));
  end

  // Strobe timing monitor: rise-to-rise interval and high width, in cycles.
  int   cyc_n = 0, rises = 0, last_rise = 0, last_interval = 0, last_width = 0;
  logic prev_stb = 1'b0;
  always @(posedge clk) begin
    #1;
    cyc_n++;
    if (stb_o && !prev_stb) begin
      last_interval = cyc_n - last_rise;
      last_rise     = cyc_n;
      rises++;
    end
    if (!stb_o && prev_stb) last_width = cyc_n - last_rise;
    prev_stb = stb_o;
  end

  task automatic wait_rise();
    int start = rises;
    int t = 0;
    while (rises == start && t < 100) begin
      @(negedge clk);
      t++;
    end
    n_checks++;
    if (rises == start) begin
      n_fail++;
      $display("FAIL rise_timeout: no strobe after %0d cycles, expected within 100", t);
    end
  endtask

  logic [7:0] seq_dat [4] = '{8'hF0, 8'hFF, 8'hA0, 8'hF0};
  int         seq_idx [4] = '{1, 2, 0, 1};

  initial begin
    // Reset with noisy inputs
    repeat (5) begin
      @(negedge clk);
      ack_force = 1'($urandom_range(0, 1));
      next_r    = 1'($urandom_range(0, 1));
      check("rst_stb", 32'(stb_o), 32'd0);
      check("rst_dat", 32'(dat_o), 32'h00);
      check("rst_idx", 32'(idx_o), 32'd0);
      check("rst_err", 32'(err_o), 32'd0);
    end
    @(negedge clk);
    ack_force = 1'b0;
    next_r    = 1'b0;
    echo      = 1'b1;
    rst_n     = 1'b1;
    @(negedge clk);
    check("first_stb", 32'(stb_o), 32'd1);
    check("first_dat", 32'(dat_o), 32'hA0);
    check("first_idx", 32'(idx_o), 32'd0);

    // Echo ACK: sequence, wrap, 1-cycle strobes, D+1 period
    for (int k = 0; k < 4; k++) begin
      wait_rise();
      check("seq_dat", 32'(dat_o), 32'(seq_dat[k]));
      check("seq_idx", 32'(idx_o), 32'(seq_idx[k]));
      check("seq_period", 32'(last_interval), 32'd9);
      check("seq_width", 32'(last_width), 32'd1);
    end

    // Skip 3 cycles into dwell
    repeat (3) @(negedge clk);
    next_r = 1'b1;
    wait_rise();
    next_r = 1'b0;
    check("skip_period", 32'(last_interval), 32'd4);
    check("skip_dat", 32'(dat_o), 32'hFF);
    check("skip_idx", 32'(idx_o), 32'd2);

    // Timeouts: 4-cycle strobes, period T+D, sticky error
    echo = 1'b0;
    wait_rise();
    check("to_width", 32'(last_width), 32'd4);
    check("to_period", 32'(last_interval), 32'd12);
    check("to_err", 32'(err_o), 32'd1);
    check("to_dat", 32'(dat_o), 32'hA0);
    wait_rise();
    check("to_period2", 32'(last_interval), 32'd12);
    check("to_idx2", 32'(idx_o), 32'd1);

    // Echo ACK again: error remains set
    echo = 1'b1;
    wait_rise();
    check("re_period", 32'(last_interval), 32'd9);
    check("re_idx", 32'(idx_o), 32'd2);
    check("re_err", 32'(err_o), 32'd1);

    // Two skip requests during one 4-cycle write collapse into one skip
    echo   = 1'b0;
    next_r = 1'b1;
    @(negedge clk);
    next_r = 1'b0;
    @(negedge clk);
    next_r = 1'b1;
    @(negedge clk);
    next_r = 1'b0;
    wait_rise();
    check("coll_period", 32'(last_interval), 32'd5);
    check("coll_idx", 32'(idx_o), 32'd0);
    wait_rise();
    check("coll_period2", 32'(last_interval), 32'd12);
    check("coll_idx2", 32'(idx_o), 32'd1);

    // Pause for 20 cycles mid-dwell
    echo = 1'b1;
    repeat (3) @(negedge clk);
    pause_r = 1'b1;
    repeat (20) @(negedge clk);
    pause_r = 1'b0;
    wait_rise();
    check("pause_period", 32'(last_interval), 32'd29);
    check("pause_idx", 32'(idx_o), 32'd2);

    // Skip during pause still fires at once
    repeat (3) @(negedge clk);
    pause_r = 1'b1;
    repeat (2) @(negedge clk);
    next_r = 1'b1;
    wait_rise();
    next_r  = 1'b0;
    pause_r = 1'b0;
    check("pskip_period", 32'(last_interval), 32'd6);
    check("pskip_idx", 32'(idx_o), 32'd0);

    // Asynchronous reset in the middle of the write of entry 2
    echo = 1'b0;
    for (int k = 0; k < 4 && idx_o != 4'd2; k++) wait_rise();
    check("pre_rst_idx", 32'(idx_o), 32'd2);
    check("pre_rst_stb", 32'(stb_o), 32'd1);
    #3 rst_n = 1'b0;
    #1;
    check("arst_stb", 32'(stb_o), 32'd0);
    check("arst_cyc", 32'(cyc_o), 32'd0);
    check("arst_dat", 32'(dat_o), 32'h00);
    check("arst_idx", 32'(idx_o), 32'd0);
    check("arst_err", 32'(err_o), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_rise();
    check("post_dat", 32'(dat_o), 32'hA0);
    check("post_idx", 32'(idx_o), 32'd0);
    check("post_err", 32'(err_o), 32'd0);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
